rr_mux_arbiter: RTL and testbench



---
 rtl/rr_mux_arbiter_pkg.sv | 20 ++
 rtl/rr_mux_arbiter_if.sv | 34 +++
 rtl/rr_mux_arbiter_mux.sv | 17 +
 rtl/rr_mux_arbiter.sv | 109 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter_pkg
// Description : Shared sizes, default burst length and FSM state encoding
//               for the round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_mux_arbiter_pkg;

  localparam int N            = 16;  // requesters, matches mux_16x1
  localparam int SW           = 4;   // select width, log2(N)
  localparam int HOLD_MAX_DEF = 4;   // default beats per grant (1..15)

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : rr_mux_arbiter_pkg
`default_nettype wire

// File: rtl/rr_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter_if
// Description : Request/data/handshake bundle between the requesters, the
//               downstream sink and the round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_mux_arbiter_if;
  import rr_mux_arbiter_pkg::*;

  logic [N-1:0]  req;    // request per source
  logic [N-1:0]  in;     // data bit per source
  logic          ready;  // downstream accepts a beat
  logic [SW-1:0] sel;    // mux select (current or last grantee)
  logic [N-1:0]  gnt;    // one-hot grant
  logic          busy;   // arbiter is in GRANT
  logic          valid;  // beat offered this cycle
  logic          out;    // muxed data bit
  logic          last;   // final beat of the burst

  // Requester / sink side
  modport master (
    output req, in, ready,
    input  sel, gnt, busy, valid, out, last
  );

  // Arbiter side
  modport slave (
    input  req, in, ready,
    output sel, gnt, busy, valid, out, last
  );

endinterface : rr_mux_arbiter_if
`default_nettype wire

// File: rtl/rr_mux_arbiter_mux.sv
`default_nettype none
// ============================================================================
// Module      : mux_16x1
// Description : 16:1 single-bit multiplexer datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_16x1 (
  input  wire logic [15:0] in_i,
  input  wire logic [3:0]  sel_i,
  output wire logic        out_o
);

  // Plain indexed select; no registers in the datapath
  assign out_o = in_i[sel_i];

endmodule : mux_16x1
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter
// Description : Round-robin scheduler sharing one mux_16x1 between 16
//               requesters; grants bounded bursts under ready/valid and
//               rotates priority after every release.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  wire logic         clk,
  input  wire logic         rst,
  rr_mux_arbiter_if.slave   bus
);

  localparam logic [SW-1:0] c_LAST_CNT = SW'(HOLD_MAX - 1);
  localparam logic [N-1:0]  c_ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  state_t        state_q;
  logic [SW-1:0] sel_q;
  logic [N-1:0]  gnt_q;
  logic          busy_q;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] cnt_q;

  logic [SW-1:0] w_win;
  logic          w_valid;
  logic          w_beat;
  logic          w_last;
  logic          w_release;
  logic          w_raw;

  // First requester at or after ptr, wrapping 15 -> 0
  function automatic logic [SW-1:0] rr_pick(input logic [N-1:0] r,
                                            input logic [SW-1:0] p);
    logic [SW-1:0] idx;
    logic          found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = p + SW'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign w_win     = rr_pick(bus.req, ptr_q);
  assign w_valid   = busy_q & bus.req[sel_q];
  assign w_beat    = w_valid & bus.ready;
  assign w_last    = w_beat & (cnt_q == c_LAST_CNT);
  // Withdrawal of the grantee's request also ends the burst
  assign w_release = w_last | ~bus.req[sel_q];

  mux_16x1 u_mux (
    .in_i  (bus.in),
    .sel_i (sel_q),
    .out_o (w_raw)
  );

  // Grant FSM: arbitrate in IDLE, count beats in GRANT, rotate on release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            state_q <= GRANT;
            sel_q   <= w_win;
            gnt_q   <= c_ONE_HOT0 << w_win;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= sel_q + SW'(1);
          end else if (w_beat) begin
            cnt_q <= cnt_q + SW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sel   = sel_q;
  assign bus.gnt   = gnt_q;
  assign bus.busy  = busy_q;
  assign bus.valid = w_valid;
  assign bus.out   = w_valid & w_raw;
  assign bus.last  = w_last;

endmodule : rr_mux_arbiter
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_arbiter
// Description : Self-checking bench for rr_mux_arbiter; expected beats are
//               queued as stimulus is applied and compared as they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

  typedef struct packed {
    logic [3:0] sel;
    logic       data;
    logic       last;
  } beat_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  beat_t sb[$];
  beat_t e_beat;
  logic [15:0] in_v;
  int   order[4];

  rr_mux_arbiter_if bus ();

  rr_mux_arbiter #(.HOLD_MAX(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int k, input logic d, input int nb, input bit end_last);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.sel  = 4'(k);
      b.data = d;
      b.last = end_last && (i == nb - 1);
      sb.push_back(b);
    end
  endtask

  // Counts grant cycles remaining until busy drops, bounded
  task automatic wait_grant(input string tag, input int exp_n);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"},   bus.sel,   0);
    chk({tag, "_gnt"},   bus.gnt,   0);
    chk({tag, "_busy"},  bus.busy,  0);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_out"},   bus.out,   0);
    chk({tag, "_last"},  bus.last,  0);
  endtask

  // Scoreboard consumer: every accepted beat must match the next expected one
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.valid === 1'b1 && bus.ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e_beat = sb.pop_front();
        chk("beat_sel",  bus.sel,  e_beat.sel);
        chk("beat_out",  bus.out,  e_beat.data);
        chk("beat_last", bus.last, e_beat.last);
        chk("beat_gnt",  bus.gnt,  16'(1) << e_beat.sel);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.in = '0;
    bus.ready = 1'b0;
    step();
    step();
    chk_reset_vals("init");
    rst = 1'b0;

    // Single requester, two back-to-back bursts with one IDLE between
    bus.req = 16'h0004;
    bus.in = 16'h0004;
    bus.ready = 1'b1;
    #1;
    chk("b_idle_busy", bus.busy, 0);
    push_burst(2, 1'b1, 4, 1'b1);
    push_burst(2, 1'b1, 4, 1'b1);
    step();
    chk("b_sel", bus.sel, 2);
    chk("b_gnt", bus.gnt, 16'h0004);
    chk("b_busy", bus.busy, 1);
    wait_grant("b_burst1_len", 4);
    chk("b_rel_gnt", bus.gnt, 0);
    chk("b_rel_sel", bus.sel, 2);
    step();
    chk("b_regrant_busy", bus.busy, 1);
    chk("b_regrant_sel", bus.sel, 2);
    wait_grant("b_burst2_len", 4);
    bus.req = '0;
    step();
    chk("b_idle_hold", bus.busy, 0);

    // Reset asserted between edges while granted, with all requests high
    bus.req = 16'hFFFF;
    bus.in = 16'hFFFF;
    push_burst(3, 1'b1, 1, 1'b0);
    step();
    chk("a_sel", bus.sel, 3);
    chk("a_busy", bus.busy, 1);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("a_rst");
    step();
    rst = 1'b0;
    bus.req = '0;
    #1;
    chk("a_after_busy", bus.busy, 0);

    // Round robin with wrap from ptr=0
    in_v = 16'h8020;
    bus.in = in_v;
    bus.req = 16'h8021;
    order[0] = 0; order[1] = 5; order[2] = 15; order[3] = 0;
    for (int i = 0; i < 4; i++) begin
      push_burst(order[i], in_v[order[i]], 4, 1'b1);
      step();
      chk("c_sel", bus.sel, order[i]);
      wait_grant("c_burst_len", 4);
    end

    // Backpressure on the grant to 5: 3 stall cycles after beat 1
    push_burst(5, in_v[5], 4, 1'b1);
    step();
    chk("d_sel", bus.sel, 5);
    step();
    bus.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("d_stall_valid", bus.valid, 1);
      chk("d_stall_last", bus.last, 0);
      chk("d_stall_busy", bus.busy, 1);
      step();
    end
    bus.ready = 1'b1;
    wait_grant("d_rest_len", 3);

    order[0] = 15; order[1] = 0;
    for (int i = 0; i < 2; i++) begin
      push_burst(order[i], in_v[order[i]], 4, 1'b1);
      step();
      chk("c2_sel", bus.sel, order[i]);
      wait_grant("c2_burst_len", 4);
    end

    // Withdrawal by requester 5 after two beats
    push_burst(5, in_v[5], 2, 1'b0);
    step();
    chk("e_sel", bus.sel, 5);
    step();
    step();
    bus.req = 16'h8001;
    #1;
    chk("e_wd_valid", bus.valid, 0);
    chk("e_wd_out", bus.out, 0);
    chk("e_wd_last", bus.last, 0);
    step();
    chk("e_rel_busy", bus.busy, 0);
    chk("e_rel_gnt", bus.gnt, 0);
    step();
    chk("e_next_sel", bus.sel, 15);
    chk("e_next_busy", bus.busy, 1);
    bus.req = 16'h8021;

    // Async reset in the middle of the burst to 15
    push_burst(15, in_v[15], 1, 1'b0);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("f_rst");
    step();
    rst = 1'b0;
    #1;
    chk("f_after_busy", bus.busy, 0);
    push_burst(0, in_v[0], 4, 1'b1);
    step();
    chk("f_sel", bus.sel, 0);
    chk("f_busy", bus.busy, 1);
    wait_grant("f_burst_len", 4);
    bus.req = '0;
    step();
    step();
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rr_mux_arbiter
`default_nettype wire
